cp_inserter: RTL and testbench

Cyclic-prefix inserter that sits directly downstream of the `ifft` stage in the OFDM transmit chain. Collects one frame of N complex time-domain samples, then emits the last CP_LEN samples (the prefix) followed by the full N-sample frame. Both sides use valid/ready streaming, so the block absorbs rate mismatch between the IFFT and the DAC-side consumer.

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/cpi_buffer.sv | 33 +++
 rtl/cp_inserter.sv | 156 +++++++++++++++
 tb/tb_cp_inserter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM transmit-chain types: default frame geometry, the CP inserter
// state encoding and the complex sample struct.
package ofdm_pkg;

    localparam int CPI_N      = 64;
    localparam int CPI_CP_LEN = 16;
    localparam int CPI_DW     = 16;

    typedef enum logic [1:0] {
        FILL,
        EMIT_CP,
        EMIT_BODY
    } cpi_state_e;

    typedef struct packed {
        logic signed [CPI_DW-1:0] re;
        logic signed [CPI_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cpi_buffer.sv
// Frame store for the CP inserter: one write port and one registered read port.
// A read of the address being written in the same cycle returns the new data.
module cpi_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        // Needed when CP_LEN=1: the prefix read coincides with the final write.
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_q <= wr_data;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: buffers N samples, then emits the last CP_LEN followed
// by the whole frame. Optional in_last framing check under CPI_FRAME_CHECK_EN.
module cp_inserter
    import ofdm_pkg::*;
#(
    parameter int N      = CPI_N,
    parameter int CP_LEN = CPI_CP_LEN,
    parameter int DW     = CPI_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_first,
    output logic          out_last,
    output logic          frame_err
);

    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);

    cpi_state_e        state_q, state_d;
    logic [AW-1:0]     wr_idx_q, wr_idx_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [2*DW-1:0]   out_data_q, out_data_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic              frame_err_q, frame_err_d;

    logic [2*DW-1:0]   rd_data;
    logic              in_fire;
    logic              out_free;
    logic              load;
    logic              frame_bad;

    assign in_fire  = in_valid && in_ready_q;
    assign out_free = !out_valid_q || out_ready;
    assign load     = out_free && (state_q != FILL);

`ifdef CPI_FRAME_CHECK_EN
    assign frame_bad = in_fire && (in_last != (wr_idx_q == IDX_LAST));
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_bad      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        frame_err_d = frame_bad;

        // rd_idx rolls from N-1 to 0 on its own, which is the prefix-to-body wrap.
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (frame_bad) begin
                        wr_idx_d = '0;
                    end else if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d = '0;
                        rd_idx_d = CP_START;
                        state_d  = EMIT_CP;
                    end else begin
                        wr_idx_d = wr_idx_q + AW'(1);
                    end
                end
            end
            EMIT_CP: begin
                if (load) begin
                    rd_idx_d = rd_idx_q + AW'(1);
                    if (rd_idx_q == IDX_LAST) state_d = EMIT_BODY;
                end
            end
            EMIT_BODY: begin
                if (load) begin
                    rd_idx_d = rd_idx_q + AW'(1);
                    if (rd_idx_q == IDX_LAST) state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_first_d = (state_q == EMIT_CP) && (rd_idx_q == CP_START);
            out_last_d  = (state_q == EMIT_BODY) && (rd_idx_q == IDX_LAST);
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Read address runs one step ahead so rd_data already holds buf[rd_idx_q].
    cpi_buffer #(
        .DEPTH (N),
        .WIDTH (2 * DW),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (wr_idx_q),
        .wr_data ({in_real, in_imag}),
        .rd_addr (rd_idx_d),
        .rd_data (rd_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_real  = out_data_q[2*DW-1:DW];
    assign out_imag  = out_data_q[DW-1:0];
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cp_inserter.sv
// Bench for cp_inserter (N=8, CP_LEN=2): directed and random frames checked against
// a prefix-then-body reference queue; framing-error case when CPI_FRAME_CHECK_EN is set.
module tb_cp_inserter;

    localparam int N  = 8;
    localparam int CP = 2;
    localparam int DW = 16;

    logic          clk, reset;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_real, in_imag;
    logic          out_valid, out_ready, out_first, out_last, frame_err;
    logic [DW-1:0] out_real, out_imag;

    cp_inserter #(.N(N), .CP_LEN(CP), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          first;
        logic          last;
    } smp_t;

    smp_t          feed_q[$];
    smp_t          exp_q[$];
    smp_t          got_q[$];
    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];

    int   n_pass = 0, n_fail = 0, n_total = 0;
    int   cyc = 0, stall_viol = 0, err_cnt = 0, ir_low_busy = 0;
    int   last_in_cyc = -1, first_ov_cyc = -1, last_ov_cyc = -1;
    logic gaps = 1'b0, tog = 1'b1;
    logic pv = 1'b0, pr = 1'b0;
    smp_t pd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: a symbol is the last CP samples of the frame, then the whole frame.
    function automatic void push_frame();
        for (int k = 0; k < N; k++)
            feed_q.push_back('{fr_re[k], fr_im[k], 1'b0, (k == N - 1)});
        for (int k = 0; k < CP; k++)
            exp_q.push_back('{fr_re[N-CP+k], fr_im[N-CP+k], (k == 0), 1'b0});
        for (int k = 0; k < N; k++)
            exp_q.push_back('{fr_re[k], fr_im[k], 1'b0, (k == N - 1)});
    endfunction

    task automatic cycle(input int rmode);
        in_valid = (feed_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        if (feed_q.size() > 0) begin
            in_real = feed_q[0].re;
            in_imag = feed_q[0].im;
            in_last = feed_q[0].last;
        end
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = tog; tog = !tog; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (pv && !pr && !(out_valid && ({out_real, out_imag, out_first, out_last} == pd)))
            stall_viol++;
        if (!in_ready && feed_q.size() > 0) ir_low_busy++;
        if (frame_err) err_cnt++;
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (in_valid && in_ready) begin
            if (feed_q.size() == 1) last_in_cyc = cyc;
            void'(feed_q.pop_front());
        end
        if (out_valid && out_ready) begin
            got_q.push_back('{out_real, out_imag, out_first, out_last});
            last_ov_cyc = cyc;
        end
        pv = out_valid;
        pr = out_ready;
        pd = '{out_real, out_imag, out_first, out_last};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        pv    = 1'b0;
    endtask

    task automatic drain(input string tag, input int rmode);
        int b = 0;
        while ((feed_q.size() > 0 || got_q.size() < exp_q.size()) && b < 500) begin
            cycle(rmode);
            b++;
        end
        repeat (4) cycle(0);
        chk({tag, ":count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s:smp%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, ":stall"}, 64'(stall_viol), 64'(0));
        if (b >= 500) do_reset();
        feed_q.delete();
        exp_q.delete();
        got_q.delete();
        stall_viol = 0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst:in_ready",  64'(in_ready),  64'(0));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:out_real",  64'(out_real),  64'(0));
        chk("rst:out_imag",  64'(out_imag),  64'(0));
        chk("rst:out_first", 64'(out_first), 64'(0));
        chk("rst:out_last",  64'(out_last),  64'(0));
        chk("rst:frame_err", 64'(frame_err), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("rst:in_ready_up", 64'(in_ready), 64'(1));

        // Ramp 1..8, free-running consumer: latency and back-to-back stream.
        for (int k = 0; k < N; k++) begin fr_re[k] = DW'(k + 1); fr_im[k] = '0; end
        push_frame();
        drain("seq", 0);
        chk("seq:latency", 64'(first_ov_cyc - last_in_cyc), 64'(2));
        chk("seq:stream",  64'(last_ov_cyc - first_ov_cyc), 64'(N + CP - 1));

        tog = 1'b1;
        push_frame();
        drain("tog", 1);

        ir_low_busy = 0;
        push_frame();
        for (int k = 0; k < N; k++) fr_re[k] = DW'(k + 11);
        push_frame();
        drain("b2b", 0);
        chk("b2b:in_ready_gap", 64'(ir_low_busy), 64'(N + CP));

        // Partial frame abandoned by reset.
        for (int k = 0; k < 5; k++) feed_q.push_back('{DW'(91 + k), DW'(7), 1'b0, 1'b0});
        for (int b = 0; b < 50 && feed_q.size() > 0; b++) cycle(0);
        do_reset();
        chk("mid:out_valid", 64'(out_valid), 64'(0));
        chk("mid:in_ready",  64'(in_ready),  64'(0));
        for (int k = 0; k < N; k++) begin fr_re[k] = DW'(k + 21); fr_im[k] = DW'(k + 100); end
        push_frame();
        drain("mid", 0);

`ifdef CPI_FRAME_CHECK_EN
        err_cnt = 0;
        for (int k = 0; k < 4; k++) feed_q.push_back('{DW'(50 + k), DW'(0), 1'b0, (k == 3)});
        drain("ferr", 0);
        chk("ferr:pulses", 64'(err_cnt), 64'(1));
        for (int k = 0; k < N; k++) begin fr_re[k] = DW'(k + 31); fr_im[k] = DW'(k + 1); end
        push_frame();
        drain("ferr_ok", 0);
        chk("ferr:no_more", 64'(err_cnt), 64'(1));
`endif

        for (int k = 0; k < N; k++) begin
            fr_re[k] = (k % 2 == 0) ? 16'h8000 : 16'h7fff;
            fr_im[k] = (k % 2 == 0) ? 16'h7fff : 16'h8000;
        end
        push_frame();
        drain("ext", 2);

        gaps = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) begin
                fr_re[k] = DW'($urandom);
                fr_im[k] = DW'($urandom);
            end
            push_frame();
            drain($sformatf("rnd%0d", f), 2);
        end
        gaps = 1'b0;

`ifndef CPI_FRAME_CHECK_EN
        chk("frame_err_tied", 64'(err_cnt), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
